// File: rtl/usbh_nes_joypad_serializer.sv
// +----------------------------------------------------------------------------+
// | usbh_nes_joypad_serializer                                                 |
// | Emulates the NES pad's 4021 shift register fed from decoded HID reports,   |
// | with stale-report timeout, opposite-direction filter and A/B autofire.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module usbh_nes_joypad_serializer #(
  parameter int c_clk_hz      = 6000000,
  parameter int c_autofire_hz = 10,
  parameter int c_timeout_ms  = 100
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_btn,
  input  logic       i_btn_valid,
  input  logic [1:0] i_turbo_en,
  input  logic       i_strobe,
  input  logic       i_rd,
  output logic       o_data,
  output logic [7:0] o_btn,
  output logic       o_stale
);

  localparam int C_TMO_LIM = c_clk_hz / 1000 * c_timeout_ms;
  localparam int C_TMO_W   = (C_TMO_LIM > 1) ? $clog2(C_TMO_LIM) : 1;
  localparam int C_HALF    = c_clk_hz / (2 * c_autofire_hz);
  localparam int C_PH_W    = (C_HALF > 1) ? $clog2(C_HALF) : 1;

  localparam logic [C_TMO_W-1:0] C_TMO_LAST = C_TMO_W'(C_TMO_LIM - 1);
  localparam logic [C_PH_W-1:0]  C_PH_LAST  = C_PH_W'(C_HALF - 1);

  logic [7:0]         r_held;
  logic [C_TMO_W-1:0] r_tmo_cnt;
  logic               r_stale;
  logic [C_PH_W-1:0]  r_ph_cnt;
  logic               r_phase;
  logic [7:0]         r_btn;
  logic [7:0]         r_sr;

  logic [C_TMO_W-1:0] w_tmo_nxt;
  logic               w_expire;
  logic [7:0]         w_filt;

  always_comb begin
    w_tmo_nxt = (r_tmo_cnt == C_TMO_LAST) ? r_tmo_cnt : r_tmo_cnt + 1'b1;
    w_expire  = (w_tmo_nxt == C_TMO_LAST);
  end

  // A fresh report always beats a timeout expiring in the same cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_held    <= 8'h00;
      r_tmo_cnt <= '0;
      r_stale   <= 1'b1;
    end else if (i_btn_valid) begin
      r_held    <= i_btn;
      r_tmo_cnt <= '0;
      r_stale   <= 1'b0;
    end else begin
      r_tmo_cnt <= w_tmo_nxt;
      if (w_expire) begin
        r_held  <= 8'h00;
        r_stale <= 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ph_cnt <= '0;
      r_phase  <= 1'b0;
    end else if (r_ph_cnt == C_PH_LAST) begin
      r_ph_cnt <= '0;
      r_phase  <= ~r_phase;
    end else begin
      r_ph_cnt <= r_ph_cnt + 1'b1;
    end
  end

  // Bit order {R,L,D,U,Start,Select,B,A}.
  always_comb begin
    w_filt = r_held;
    if (r_held[7] && r_held[6]) w_filt[7:6] = 2'b00;
    if (r_held[5] && r_held[4]) w_filt[5:4] = 2'b00;
    if (i_turbo_en[0]) w_filt[0] = r_held[0] & r_phase;
    if (i_turbo_en[1]) w_filt[1] = r_held[1] & r_phase;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_btn <= 8'h00;
    end else begin
      r_btn <= w_filt;
    end
  end

  // Strobe reload has priority over a shift; shifting back-fills with 1s.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sr <= 8'h00;
    end else if (i_strobe) begin
      r_sr <= r_btn;
    end else if (i_rd) begin
      r_sr <= {1'b1, r_sr[7:1]};
    end
  end

  assign o_data  = r_sr[0];
  assign o_btn   = r_btn;
  assign o_stale = r_stale;

endmodule

`default_nettype wire

// File: tb/tb_usbh_nes_joypad_serializer.sv
// +----------------------------------------------------------------------------+
// | tb_usbh_nes_joypad_serializer                                              |
// | Scoreboard-driven bench for the NES joypad serializer.                     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_usbh_nes_joypad_serializer;

  logic       clk;
  logic       rst_n;
  logic [7:0] btn;
  logic       btn_valid;
  logic [1:0] turbo_en;
  logic       strobe;
  logic       rd;
  logic       data;
  logic [7:0] obtn;
  logic       stale;

  int checks;
  int errors;
  logic       q_bit[$];
  logic [7:0] q_byte[$];

  // 1 kHz clock model: autofire half-period 50 cycles, timeout limit 10 cycles.
  usbh_nes_joypad_serializer #(
    .c_clk_hz(1000),
    .c_autofire_hz(10),
    .c_timeout_ms(10)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_btn(btn),
    .i_btn_valid(btn_valid),
    .i_turbo_en(turbo_en),
    .i_strobe(strobe),
    .i_rd(rd),
    .o_data(data),
    .o_btn(obtn),
    .o_stale(stale)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic latch_report(input logic [7:0] b);
    btn       = b;
    btn_valid = 1'b1;
    strobe    = 1'b1;
    cyc(4);
    strobe    = 1'b0;
    cyc(1);
  endtask

  task automatic read_and_check(input string name);
    logic e;
    while (q_bit.size() > 0) begin
      e = q_bit.pop_front();
      checks++;
      if (data !== e) begin
        errors++;
        $display("FAIL %s: o_data got %0b expected %0b", name, data, e);
      end
      rd = 1'b1;
      cyc(1);
      rd = 1'b0;
      cyc(1);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; btn = 8'h00; btn_valid = 1'b0; turbo_en = 2'b00;
    strobe = 1'b0; rd = 1'b0;
    cyc(2);
    checks++;
    if (data !== 1'b0 || obtn !== 8'h00 || stale !== 1'b1) begin
      errors++;
      $display("FAIL reset: data=%0b btn=%h stale=%0b expected 0/00/1", data, obtn, stale);
    end
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_basic_read;
    latch_report(8'h09);
    checks++;
    if (stale !== 1'b0) begin
      errors++;
      $display("FAIL basic_stale: got %0b expected 0", stale);
    end
    q_bit = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    read_and_check("basic_read");
  endtask

  task automatic test_strobe_held;
    btn = 8'h01; btn_valid = 1'b1; strobe = 1'b1;
    cyc(4);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (data !== 1'b1) begin
        errors++;
        $display("FAIL strobe_held[%0d]: o_data got %0b expected 1", i, data);
      end
      rd = 1'b1; cyc(1); rd = 1'b0; cyc(1);
    end
    strobe = 1'b0;
    cyc(1);
    q_bit = '{1'b1, 1'b0, 1'b0, 1'b0};
    read_and_check("strobe_release");
  endtask

  task automatic test_opposite;
    logic [7:0] stim[4];
    logic [7:0] e;
    stim = '{8'hC0, 8'h30, 8'h80, 8'h52};
    q_byte = '{8'h00, 8'h00, 8'h80, 8'h52};
    btn_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      btn = stim[i];
      cyc(3);
      e = q_byte.pop_front();
      checks++;
      if (obtn !== e) begin
        errors++;
        $display("FAIL opposite[%0d]: o_btn got %h expected %h", i, obtn, e);
      end
    end
  endtask

  task automatic test_autofire;
    logic prev;
    int   gap;
    bit   b_ok;
    btn = 8'h03; btn_valid = 1'b1; turbo_en = 2'b01;
    cyc(3);
    b_ok = 1'b1;
    prev = obtn[0];
    gap  = 0;
    // Find first edge, then measure two full half-periods.
    for (int k = 0; k < 3; k++) begin
      gap = 0;
      do begin
        cyc(1);
        gap++;
        if (obtn[1] !== 1'b1) b_ok = 1'b0;
      end while (obtn[0] === prev && gap < 200);
      prev = obtn[0];
      if (k > 0) begin
        checks++;
        if (gap != 50) begin
          errors++;
          $display("FAIL autofire_period[%0d]: got %0d cycles expected 50", k, gap);
        end
      end
    end
    checks++;
    if (!b_ok) begin
      errors++;
      $display("FAIL autofire_b_steady: o_btn[1] dropped, expected 1");
    end
    turbo_en = 2'b00;
    cyc(3);
  endtask

  task automatic test_timeout;
    logic       es;
    logic [7:0] eb;
    btn = 8'hFF; btn_valid = 1'b1;
    cyc(1);
    btn_valid = 1'b0;
    for (int j = 1; j <= 10; j++) begin
      cyc(1);
      es = (j >= 9);
      eb = (j >= 10) ? 8'h00 : 8'h00 | {2'b00, 2'b00, 4'hF};
      eb = (j >= 10) ? 8'h00 : 8'h0F;
      checks++;
      if (stale !== es || obtn !== eb) begin
        errors++;
        $display("FAIL timeout[%0d]: stale=%0b btn=%h expected %0b/%h", j, stale, obtn, es, eb);
      end
    end
    btn = 8'h01; btn_valid = 1'b1;
    cyc(1);
    checks++;
    if (stale !== 1'b0) begin
      errors++;
      $display("FAIL timeout_recover: stale got %0b expected 0", stale);
    end
  endtask

  task automatic test_reset_mid_read;
    latch_report(8'h09);
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1; cyc(1); rd = 1'b0; cyc(1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (data !== 1'b0 || stale !== 1'b1 || obtn !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid: data=%0b stale=%0b btn=%h expected 0/1/00", data, stale, obtn);
    end
    btn_valid = 1'b0; strobe = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    q_bit = '{1'b0, 1'b0, 1'b0};
    read_and_check("post_reset_read");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_basic_read;
    test_strobe_held;
    test_opposite;
    test_autofire;
    test_timeout;
    test_reset_mid_read;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
